// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared CPU widths, defaults and the prefetch-queue entry type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int IQ_DEPTH = 4;
  localparam int ADDR_W   = 32;
  localparam int INSTR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } iq_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_queue.sv
// ============================================================================
// Module : inst_queue
// Brief  : Fetch-to-decode instruction prefetch FIFO, flushed on taken branch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = ADDR_W,
  parameter int DW    = INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [AW-1:0]              i_in_pc,
  input  logic [DW-1:0]              i_in_instr,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [AW-1:0]              o_out_pc,
  output logic [DW-1:0]              o_out_instr,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  logic [AW-1:0]  r_pc_mem    [DEPTH];
  logic [DW-1:0]  r_instr_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Handshake readiness depends only on registered occupancy, never on same-cycle pops.
  assign w_in_ready  = (r_count != c_FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = i_in_valid  & w_in_ready  & ~i_flush;
  assign w_pop       = w_out_valid & i_out_ready & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= i_in_pc;
      r_instr_mem[r_wr_ptr] <= i_in_instr;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_pc    = w_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign o_out_instr = w_out_valid ? r_instr_mem[r_rd_ptr] : DW'(NOP_INSTR);
  assign o_count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ============================================================================
// Module : tb_inst_queue
// Brief  : Directed self-checking bench for the instruction prefetch queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_queue;

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_in_pc;
  logic [31:0] i_in_instr;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_pc;
  logic [31:0] o_out_instr;
  logic [2:0]  o_count;

  int n_cmp;
  int n_err;

  inst_queue #(.DEPTH(4), .AW(32), .DW(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_pc     (i_in_pc),
    .i_in_instr  (i_in_instr),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_pc    (o_out_pc),
    .o_out_instr (o_out_instr),
    .o_count     (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; checks and new drives happen here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    i_in_valid  = v;
    i_in_pc     = pc;
    i_in_instr  = instr_of(pc);
    i_out_ready = rdy;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    i_flush = 1'b0;
    drive(1'b1, 32'h50, 1'b0);

    // Reset held with a valid input present
    tick();
    tick();
    chk("rst_count",  64'(o_count),     64'd0);
    chk("rst_ovalid", 64'(o_out_valid), 64'd0);
    chk("rst_opc",    64'(o_out_pc),    64'd0);
    chk("rst_oinstr", 64'(o_out_instr), 64'd0);
    chk("rst_iready", 64'(o_in_ready),  64'd1);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tick();

    // Fill
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0);
      tick();
      if (i == 0) begin
        chk("fill_lat_valid", 64'(o_out_valid), 64'd1);
        chk("fill_lat_pc",    64'(o_out_pc),    64'h0);
      end
    end
    chk("full_count",  64'(o_count),    64'd4);
    chk("full_iready", 64'(o_in_ready), 64'd0);
    drive(1'b1, 32'h10, 1'b0);
    tick();
    chk("overpush_count", 64'(o_count), 64'd4);

    // Drain
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc",    64'(o_out_pc),    64'(4 * i));
      chk("drain_instr", 64'(o_out_instr), 64'(instr_of(32'(4 * i))));
      tick();
    end
    chk("drain_ovalid", 64'(o_out_valid), 64'd0);
    chk("drain_count",  64'(o_count),     64'd0);

    // Streaming across pointer wrap
    drive(1'b1, 32'h0, 1'b1);
    tick();
    chk("stream_count0", 64'(o_count),  64'd1);
    chk("stream_pc0",    64'(o_out_pc), 64'h0);
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1);
      tick();
      chk("stream_count", 64'(o_count),  64'd1);
      chk("stream_pc",    64'(o_out_pc), 64'(4 * i));
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("stream_end_count", 64'(o_count), 64'd0);

    // Flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h20 + 4 * i), 1'b0);
      tick();
    end
    chk("preflush_count", 64'(o_count), 64'd3);
    i_flush = 1'b1;
    drive(1'b1, 32'h2C, 1'b1);
    tick();
    i_flush = 1'b0;
    chk("flush_count",  64'(o_count),     64'd0);
    chk("flush_ovalid", 64'(o_out_valid), 64'd0);
    chk("flush_iready", 64'(o_in_ready),  64'd1);
    chk("flush_opc",    64'(o_out_pc),    64'd0);
    drive(1'b1, 32'h40, 1'b0);
    tick();
    chk("postflush_pc",    64'(o_out_pc), 64'h40);
    chk("postflush_count", 64'(o_count),  64'd1);

    // Full with pop: push refused, pop accepted
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h50 + 4 * i), 1'b0);
      tick();
    end
    chk("fp_count4", 64'(o_count),    64'd4);
    chk("fp_iready", 64'(o_in_ready), 64'd0);
    drive(1'b1, 32'h60, 1'b1);
    tick();
    chk("fp_count3", 64'(o_count),  64'd3);
    chk("fp_pc",     64'(o_out_pc), 64'h50);
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("fp_drain_pc", 64'(o_out_pc), 64'(32'h50 + 4 * i));
      tick();
    end
    chk("fp_drain_ovalid", 64'(o_out_valid), 64'd0);

    // Asynchronous reset between edges
    drive(1'b1, 32'h70, 1'b0);
    tick();
    drive(1'b1, 32'h74, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("ar_count_pre", 64'(o_count), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_count",  64'(o_count),     64'd0);
    chk("ar_ovalid", 64'(o_out_valid), 64'd0);
    chk("ar_opc",    64'(o_out_pc),    64'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h100, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("ar_post_pc",     64'(o_out_pc),    64'h100);
    chk("ar_post_ovalid", 64'(o_out_valid), 64'd1);
    chk("ar_post_count",  64'(o_count),     64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_queue.md
# inst_queue

Instruction prefetch queue between the fetch stage and the decode stage. It accepts {PC, instruction} pairs produced by fetch and instruction memory, buffers up to DEPTH entries, and presents them to decode through a valid/ready handshake. On a taken branch it is flushed so that no wrong-path instruction reaches decode.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- AW, 32, PC width
- DW, 32, instruction width
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- flush  in  1  taken-branch indication (Z & B from fetch); discards queue contents
- in_valid  in  1  fetch presents a valid pair this cycle
- in_ready  out  1  queue can accept; fetch must hold PC when low
- in_pc  in  AW  PC of incoming instruction
- in_instr  in  DW  incoming instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  AW  PC of head entry
- out_instr  out  DW  head instruction word
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry register array of {pc, instr}; wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH; occupancy is held in the count register.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). Depends only on registered state; a pop in the same cycle does not free a slot for a push when full.
- out_valid = (count != 0). out_pc/out_instr = entry at rd_ptr when out_valid, else 0 (NOP encoding).
- push only: write entry at wr_ptr, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count−1.
- push and pop together (count in 1..DEPTH−1): write and read both happen; count unchanged.
- flush (highest priority, below reset): wr_ptr, rd_ptr, and count all cleared to 0; any push or pop in that cycle is discarded. Array contents are not cleared (they are unreachable).
- No bypass: an empty queue never forwards in_* to out_* in the same cycle.
- Overflow and underflow are impossible by construction. A push attempted while in_ready is low is ignored, and the fetch stage is responsible for holding.

## Timing
- Reset (reset=0, asynchronous): count=0, pointers=0, in_ready=1, out_valid=0, out_pc=0, out_instr=0. Release is taken at the next clock edge.
- Latency: an entry pushed at edge N is visible on out_* after edge N (out_valid high in cycle N+1). Minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 entry per cycle sustained when count is in 1..DEPTH−1.
- flush sampled at edge N: from cycle N+1, out_valid=0 and in_ready=1. The first post-branch push is accepted at edge N+1 or later.
- Reset asserted mid-operation: outputs take their reset values without waiting for a clock edge. Any in-flight handshake is lost.
- All outputs are registered-state functions (count, pointers, array); there are no combinational paths from in_* or out_ready to any output.

## Structure
- Shared package cpu_pkg contains:
  - IQ_DEPTH default (4)
  - ADDR_W=32 and INSTR_W=32
  - NOP_INSTR=32'h00000000
  - packed type iq_entry_t {pc, instr}
- No sub-module; the array, pointers, and counter live in one module. The top-level CPU instantiates it between Fetch/instruction memory and the decoder, with flush driven by the branch-taken signal.

## Test plan
- Reset: hold reset=0 with in_valid=1 → count=0, out_valid=0, out_pc=0, in_ready=1, with no change across edges.
- Fill/drain: out_ready=0, push PCs 0x00, 0x04, 0x08, 0x0C → count=4, in_ready=0. A fifth push of 0x10 is ignored. Then out_ready=1 → out_pc sequence 0x00, 0x04, 0x08, 0x0C, then out_valid=0.
- Streaming with wrap: in_valid=out_ready=1 for 10 cycles with PC +4 from 0x00 → count holds at 1 after the first push, out_pc lags in_pc by 1 cycle, and the order is intact across pointer wrap.
- Flush with simultaneous push/pop: count=3 (0x20, 0x24, 0x28), flush=1 with in_valid=1 (0x2C) and out_ready=1 → next cycle count=0, out_valid=0. Then push 0x40 → out_pc=0x40.
- Full with pop: count=4, in_valid=1, out_ready=1 → pop accepted, push refused (in_ready=0), count=3.
- Asynchronous reset mid-stream: count=2, pull reset low between edges → count and out_valid reach 0 before the next edge. After release, the first push of 0x100 appears on out_pc one cycle later.
